life_engine_param: RTL and testbench

LIFE_ENGINE_PARAM -- requirements
Module: life_engine_param

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_row_eval.sv | 40 ++++
 rtl/life_engine_param.sv | 144 ++++++++++++++
 tb/tb_life_engine_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared encodings, FSM states and Life rule constants for the life engine.
package life_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_PROG  = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;
  localparam logic [1:0] MODE_PAUSE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROG    = 3'd1,
    S_COMPUTE = 3'd2,
    S_COMMIT  = 3'd3,
    S_PAUSE   = 3'd4
  } fsm_t;

  localparam int BIRTH       = 3;
  localparam int SURVIVE_MIN = 2;
  localparam int SURVIVE_MAX = 3;
  localparam int GEN_W       = 16;

  function automatic logic next_cell(input logic alive, input logic [3:0] n);
    if (alive) return (n >= 4'(SURVIVE_MIN)) && (n <= 4'(SURVIVE_MAX));
    return n == 4'(BIRTH);
  endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-generation evaluation of one grid row from its three source rows.
// Column neighbours wrap when LIFE_WRAP_EN is defined, otherwise off-grid cells are dead.
module life_row_eval
  import life_pkg::*;
#(
  parameter int COLS = 7
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] nxt
);

  // Extended rows: bit 0 is column -1, bit COLS+1 is column COLS.
  logic [COLS+1:0] a_ext;
  logic [COLS+1:0] m_ext;
  logic [COLS+1:0] b_ext;
  logic [3:0]      n;

  always_comb begin
`ifdef LIFE_WRAP_EN
    a_ext = {above[0], above, above[COLS-1]};
    m_ext = {cur[0], cur, cur[COLS-1]};
    b_ext = {below[0], below, below[COLS-1]};
`else
    a_ext = {1'b0, above, 1'b0};
    m_ext = {1'b0, cur, 1'b0};
    b_ext = {1'b0, below, 1'b0};
`endif
    nxt = '0;
    n   = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 4'(a_ext[c]) + 4'(a_ext[c+1]) + 4'(a_ext[c+2]) +
          4'(m_ext[c])                  + 4'(m_ext[c+2]) +
          4'(b_ext[c]) + 4'(b_ext[c+1]) + 4'(b_ext[c+2]);
      nxt[c] = next_cell(m_ext[c+1], n);
    end
  end

endmodule

// File: rtl/life_engine_param.sv
// Row-serial Game of Life engine: one row per clka negedge into a shadow buffer, then commit.
// Build option LIFE_WRAP_EN selects a toroidal grid; default is a bounded plane.
module life_engine_param
  import life_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 7
) (
  input  logic                 clka,
  input  logic                 stop,
  input  logic [1:0]           state,
  input  logic                 btn0,
  input  logic                 btn1,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 busy,
  output logic                 stable,
  output logic                 extinct,
  output logic [2:0]           dbg_state
);

  localparam int CELLS = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(CELLS);

  fsm_t            fsm, fsm_nxt;
  logic [RW-1:0]   row, row_nxt;
  logic [CW-1:0]   cursor;
  logic [CELLS-1:0] shadow;
  logic            btn0_q, btn1_q;
  logic            rise0, rise1;
  logic            do_clear, do_row, do_commit, do_prog;
  logic [COLS-1:0] row_above, row_cur, row_below, row_next;

  assign rise0     = btn0 & ~btn0_q;
  assign rise1     = btn1 & ~btn1_q;
  assign busy      = (fsm == S_COMPUTE) || (fsm == S_COMMIT);
  assign dbg_state = fsm;

  // Source rows always come from grid, so the shadow fill never sees partial results.
  always_comb begin
    row_cur   = grid[int'(row)*COLS +: COLS];
    row_above = '0;
    row_below = '0;
    if (row != '0) row_above = grid[(int'(row)-1)*COLS +: COLS];
`ifdef LIFE_WRAP_EN
    else           row_above = grid[(ROWS-1)*COLS +: COLS];
`endif
    if (row != RW'(ROWS-1)) row_below = grid[(int'(row)+1)*COLS +: COLS];
`ifdef LIFE_WRAP_EN
    else                    row_below = grid[0 +: COLS];
`endif
  end

  life_row_eval #(.COLS(COLS)) u_row_eval (
    .above (row_above),
    .cur   (row_cur),
    .below (row_below),
    .nxt   (row_next)
  );

  always_ff @(negedge clka or posedge stop) begin
    if (stop) begin
      fsm <= S_IDLE;
      row <= '0;
    end else begin
      fsm <= fsm_nxt;
      row <= row_nxt;
    end
  end

  // A commit is atomic: once in S_COMMIT it completes whatever mode follows, unless idle clears.
  always_comb begin
    fsm_nxt   = fsm;
    row_nxt   = '0;
    do_clear  = 1'b0;
    do_row    = 1'b0;
    do_commit = (fsm == S_COMMIT);
    do_prog   = 1'b0;
    case (state)
      MODE_IDLE: begin
        fsm_nxt  = S_IDLE;
        do_clear = 1'b1;
      end
      MODE_PROG: begin
        fsm_nxt = S_PROG;
        do_prog = (fsm != S_COMMIT) && (rise0 ^ rise1);
      end
      MODE_RUN: begin
        if (fsm == S_COMPUTE) begin
          do_row = 1'b1;
          if (row == RW'(ROWS-1)) begin
            fsm_nxt = S_COMMIT;
          end else begin
            fsm_nxt = S_COMPUTE;
            row_nxt = row + 1'b1;
          end
        end else begin
          fsm_nxt = S_COMPUTE;
        end
      end
      default: fsm_nxt = S_PAUSE;
    endcase
  end

  always_ff @(negedge clka or posedge stop) begin
    if (stop) begin
      grid      <= '0;
      shadow    <= '0;
      cursor    <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      btn0_q    <= 1'b0;
      btn1_q    <= 1'b0;
    end else begin
      btn0_q <= btn0;
      btn1_q <= btn1;
      if (do_clear) begin
        grid      <= '0;
        shadow    <= '0;
        cursor    <= '0;
        gen_count <= '0;
        stable    <= 1'b0;
        extinct   <= 1'b0;
      end else begin
        if (do_row) shadow[int'(row)*COLS +: COLS] <= row_next;
        if (do_commit) begin
          grid      <= shadow;
          gen_count <= (gen_count == '1) ? gen_count : gen_count + 1'b1;
          stable    <= (shadow == grid);
          extinct   <= (shadow == '0);
        end
        if (do_prog) begin
          grid[cursor] <= rise1;
          cursor       <= (cursor == CW'(CELLS-1)) ? '0 : cursor + 1'b1;
          stable       <= 1'b0;
          extinct      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_life_engine_param.sv
// Bench for life_engine_param: cell-array Life model, per-cycle scoreboard, directed pattern checks.
module tb_life_engine_param;

  localparam int ROWS = 7;
  localparam int COLS = 7;
  localparam int N    = ROWS * COLS;
  localparam int W    = N + 19;

  logic         clka = 1'b0;
  logic         stop = 1'b1;
  logic [1:0]   state = 2'b00;
  logic         btn0 = 1'b0;
  logic         btn1 = 1'b0;
  logic [N-1:0] grid;
  logic [15:0]  gen_count;
  logic         busy, stable, extinct;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  life_engine_param #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clka      (clka),
    .stop      (stop),
    .state     (state),
    .btn0      (btn0),
    .btn1      (btn1),
    .grid      (grid),
    .gen_count (gen_count),
    .busy      (busy),
    .stable    (stable),
    .extinct   (extinct),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clka = ~clka;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [N-1:0] m_grid;
  logic [15:0]  m_gen;
  bit           m_stable, m_extinct, m_run, pb0, pb1;
  int           m_phase, m_cursor;

  function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
    logic [N-1:0] r;
    int n, rr, cc;
    r = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        n = 0;
        for (int di = -1; di <= 1; di++)
          for (int dj = -1; dj <= 1; dj++) begin
            if (di == 0 && dj == 0) continue;
            rr = i + di;
            cc = j + dj;
`ifdef LIFE_WRAP_EN
            rr = (rr + ROWS) % ROWS;
            cc = (cc + COLS) % COLS;
`else
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
`endif
            n += int'(g[rr*COLS+cc]);
          end
        if (g[i*COLS+j]) r[i*COLS+j] = (n == 2 || n == 3);
        else             r[i*COLS+j] = (n == 3);
      end
    return r;
  endfunction

  function automatic logic [W-1:0] model_pack();
    return {m_grid, m_gen, m_run, m_stable, m_extinct};
  endfunction

  task automatic model_clear();
    m_grid = '0; m_gen = '0; m_stable = 0; m_extinct = 0;
    m_run = 0; m_phase = 0; m_cursor = 0;
  endtask

  always @(negedge clka or posedge stop) begin
    bit r0, r1;
    logic [N-1:0] ng;
    if (stop) begin
      model_clear();
      pb0 = 0;
      pb1 = 0;
      exp_q.delete();
    end else begin
      r0 = btn0 && !pb0;
      r1 = btn1 && !pb1;
      if (state == 2'b00) begin
        model_clear();
      end else if (m_run && m_phase == ROWS) begin
        ng        = life_next(m_grid);
        m_stable  = (ng == m_grid);
        m_extinct = (ng == '0);
        m_grid    = ng;
        if (m_gen != 16'hFFFF) m_gen = m_gen + 16'd1;
        m_run   = (state == 2'b10);
        m_phase = 0;
      end else if (state == 2'b10) begin
        if (m_run) m_phase++;
        else begin m_run = 1; m_phase = 0; end
      end else begin
        m_run = 0;
        if (state == 2'b01 && (r0 ^ r1)) begin
          m_grid[m_cursor] = r1;
          m_cursor  = (m_cursor + 1) % N;
          m_stable  = 0;
          m_extinct = 0;
        end
      end
      pb0 = btn0;
      pb1 = btn1;
    end
    exp_q.push_back(model_pack());
  end

  // ---------------- scoreboard ----------------
  always @(posedge clka) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({grid, gen_count, busy, stable, extinct} !== e) begin
        errors++;
        $display("FAIL model_cmp t=%0t got grid=%h gen=%0d busy=%b stable=%b extinct=%b exp grid=%h gen=%0d busy=%b stable=%b extinct=%b",
                 $time, grid, gen_count, busy, stable, extinct,
                 e[W-1:19], e[18:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clka);
    #1;
  endtask

  task automatic go_idle();
    state = 2'b00; btn0 = 0; btn1 = 0;
    tick(2);
  endtask

  task automatic pulse(input bit b0, input bit b1);
    btn0 = b0; btn1 = b1;
    tick(1);
    btn0 = 0; btn1 = 0;
    tick(1);
  endtask

  task automatic program_pattern(input logic [N-1:0] pat);
    go_idle();
    state = 2'b01;
    tick(1);
    for (int i = 0; i < N; i++) pulse(!pat[i], pat[i]);
  endtask

  task automatic run_gens(input int n);
    state = 2'b10;
    tick(1 + n * (ROWS + 1));
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [N-1:0] pat, pat2;

  initial begin
    tick(2);
    stop = 0;
    tick(1);
    check("reset_grid", 64'(grid), 64'd0);
    check("reset_gen", 64'(gen_count), 64'd0);
    check("reset_flags", 64'({busy, stable, extinct}), 64'd0);

    // blinker: horizontal row 3 cols 2..4 <-> vertical col 3 rows 2..4
    pat  = '0; pat[23] = 1; pat[24] = 1; pat[25] = 1;
    pat2 = '0; pat2[17] = 1; pat2[24] = 1; pat2[31] = 1;
    program_pattern(pat);
    check("blinker_prog", 64'(grid), 64'(pat));
    run_gens(1);
    check("blinker_gen1", 64'(grid), 64'(pat2));
    check("blinker_busy", 64'(busy), 64'd1);
    tick(ROWS + 1);
    check("blinker_gen2", 64'(grid), 64'(pat));
    check("blinker_cnt2", 64'(gen_count), 64'd2);
    check("blinker_stable", 64'(stable), 64'd0);

    // block still life
    pat = '0; pat[0] = 1; pat[1] = 1; pat[7] = 1; pat[8] = 1;
    program_pattern(pat);
    run_gens(1);
    check("block_grid", 64'(grid), 64'(pat));
    check("block_flags", 64'({stable, extinct}), 64'b10);
    check("block_cnt", 64'(gen_count), 64'd1);
    state = 2'b01;
    tick(1);
    pulse(1, 0);
    check("prog_clears_stable", 64'(stable), 64'd0);
    check("prog_keeps_cnt", 64'(gen_count), 64'd1);

    // lone cell dies
    pat = '0; pat[24] = 1;
    program_pattern(pat);
    run_gens(1);
    check("single_grid", 64'(grid), 64'd0);
    check("single_extinct", 64'(extinct), 64'd1);

    // glider heading SE from the bottom-right corner
    pat = '0; pat[33] = 1; pat[41] = 1; pat[46] = 1; pat[47] = 1; pat[48] = 1;
    program_pattern(pat);
    run_gens(28);
`ifdef LIFE_WRAP_EN
    check("glider_wrap_grid", 64'(grid), 64'(pat));
    check("glider_wrap_pop", 64'($countones(grid)), 64'd5);
`else
    check("glider_no_wrap_top", 64'(grid[20:0]), 64'd0);
    check("glider_cnt", 64'(gen_count), 64'd28);
`endif

    // pause at row 4, resume from row 0
    pat  = '0; pat[23] = 1; pat[24] = 1; pat[25] = 1;
    pat2 = '0; pat2[17] = 1; pat2[24] = 1; pat2[31] = 1;
    program_pattern(pat);
    state = 2'b10;
    tick(5);
    state = 2'b11;
    tick(1);
    check("pause_grid", 64'(grid), 64'(pat));
    check("pause_cnt", 64'(gen_count), 64'd0);
    check("pause_busy", 64'(busy), 64'd0);
    tick(3);
    run_gens(1);
    check("resume_grid", 64'(grid), 64'(pat2));
    check("resume_cnt", 64'(gen_count), 64'd1);

    // reset mid-compute
    tick(3);
    #2 stop = 1;
    #1 check("stop_outputs", 64'({grid, gen_count, busy, stable, extinct}), 64'd0);
    state = 2'b00;
    tick(2);
    stop = 0;
    tick(2);
    check("stop_release_grid", 64'(grid), 64'd0);
    check("stop_release_cnt", 64'(gen_count), 64'd0);

    // 50 btn1 edges wrap the cursor; simultaneous edges ignored
    go_idle();
    state = 2'b01;
    tick(1);
    for (int i = 0; i < 50; i++) pulse(0, 1);
    check("wrap_all_live", 64'(grid), 64'({N{1'b1}}));
    pulse(1, 1);
    check("both_ignored", 64'(grid), 64'({N{1'b1}}));
    pulse(1, 0);
    pat = '1; pat[1] = 0;
    check("cursor_after_both", 64'(grid), 64'(pat));

    // randomized mode/button traffic against the model
    for (int it = 0; it < 600; it++) begin
      int sel, hold;
      sel = $urandom_range(0, 19);
      if (sel == 0)       state = 2'b00;
      else if (sel <= 5)  state = 2'b01;
      else if (sel <= 17) state = 2'b10;
      else                state = 2'b11;
      hold = (state == 2'b10) ? $urandom_range(1, 40) : $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        btn0 = 1'($urandom_range(0, 1));
        btn1 = 1'($urandom_range(0, 1));
        tick(1);
      end
      if ($urandom_range(0, 40) == 0) begin
        #2 stop = 1;
        tick(1);
        stop = 0;
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
